studio2_keypad: RTL and testbench

- Converts MiSTer PS/2 key events into the two RCA Studio II 10-key keypads.
- Holds the CPU-written key-select latch (OUT 2) and drives the active-low external flags EF3 (keypad 1) and EF4 (keypad 2) into the CDP1802 EF bus.
- Sits between the HPS ps2_key input and the CPU flag logic in the console top level. It replaces the ad-hoc single-button decode there.
- Stretches short key taps so the BIOS, which polls once per video frame, cannot miss them.

---
 rtl/studio2_pkg.sv | 35 +++
 rtl/studio2_keypad_pad.sv | 61 ++++++
 rtl/studio2_keypad.sv | 73 +++++++
 tb/tb_studio2_keypad.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/studio2_pkg.sv
// Shared constants and the PS/2 scan-code decode for the Studio II keypads.
package studio2_pkg;

    // N-line value of the CPU output cycle that writes the key-select latch
    localparam logic [2:0] KEY_PORT = 3'd2;

    typedef logic [9:0] keymask_t;

    // Index k of each table holds the scan code for digit k
    localparam logic [7:0] KP1_CODES [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };
    localparam logic [7:0] KP2_CODES [10] = '{
        8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
    };

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } digit_t;

    // Look a scan code up in the table of one pad (pad2=0 -> keypad 1)
    function automatic digit_t decode_digit(input logic [7:0] code, input logic pad2);
        digit_t r;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            if (code == (pad2 ? KP2_CODES[i] : KP1_CODES[i])) begin
                r.hit = 1'b1;
                r.idx = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/studio2_keypad_pad.sv
// One 10-key pad: key-down mask with minimum-hold stretching of short taps.
module studio2_keypad_pad
    import studio2_pkg::*;
#(
    parameter logic [19:0] MIN_HOLD = 20'd100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ev_make,
    input  logic       ev_break,
    input  logic [3:0] digit,
    output keymask_t   down
);

    // MIN_HOLD=0 must not wrap the counter; it simply never goes nonzero
    localparam logic [19:0] LOAD = (MIN_HOLD == 20'd0) ? 20'd0 : MIN_HOLD - 20'd1;

    keymask_t    pending;
    keymask_t    down_nx;
    keymask_t    pend_nx;
    keymask_t    bit_k;
    logic [19:0] hold_cnt;
    logic [19:0] cnt_nx;

    // Next-state: break, then hold expiry, then make (a make overrides expiry)
    always_comb begin
        bit_k   = keymask_t'(1) << digit;
        down_nx = down;
        pend_nx = pending;
        cnt_nx  = hold_cnt;
        if (hold_cnt != 20'd0) cnt_nx = hold_cnt - 20'd1;
        if (ev_break) begin
            if (hold_cnt == 20'd0) down_nx = down_nx & ~bit_k;
            else                   pend_nx = pend_nx | bit_k;
        end
        // Counter reaches zero on this edge: deferred releases take effect
        if (hold_cnt == 20'd1 && !ev_make) begin
            down_nx = down_nx & ~pend_nx;
            pend_nx = '0;
        end
        if (ev_make) begin
            down_nx = down_nx | bit_k;
            pend_nx = pend_nx & ~bit_k;
            cnt_nx  = LOAD;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            down     <= '0;
            pending  <= '0;
            hold_cnt <= '0;
        end else begin
            down     <= down_nx;
            pending  <= pend_nx;
            hold_cnt <= cnt_nx;
        end
    end

endmodule

// File: rtl/studio2_keypad.sv
// PS/2 to RCA Studio II dual keypad bridge with CPU select latch and EF3/EF4 flags.
module studio2_keypad
    import studio2_pkg::*;
#(
    parameter logic [19:0] MIN_HOLD  = 20'd100000,
    parameter logic [3:0]  SEL_RESET = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        io_out,
    input  logic [2:0]  io_n,
    input  logic [7:0]  io_dout,
    output logic        ef3_n,
    output logic        ef4_n,
    output logic [3:0]  key_sel,
    output logic [9:0]  kp1_down,
    output logic [9:0]  kp2_down
);

    logic   tog_prev;
    logic   ev;
    logic   unused_dout_hi;
    digit_t dec1;
    digit_t dec2;
    logic   hit1;
    logic   hit2;

    assign unused_dout_hi = ^io_dout[7:4];

    // A PS/2 event is any change of the toggle strobe; extended codes never decode
    always_comb begin
        ev   = ps2_key[10] ^ tog_prev;
        dec1 = decode_digit(ps2_key[7:0], 1'b0);
        dec2 = decode_digit(ps2_key[7:0], 1'b1);
        hit1 = ev && !ps2_key[8] && dec1.hit;
        hit2 = ev && !ps2_key[8] && dec2.hit;
    end

    studio2_keypad_pad #(.MIN_HOLD(MIN_HOLD)) u_pad1 (
        .clk      (clk),
        .reset    (reset),
        .ev_make  (hit1 && ps2_key[9]),
        .ev_break (hit1 && !ps2_key[9]),
        .digit    (dec1.idx),
        .down     (kp1_down)
    );

    studio2_keypad_pad #(.MIN_HOLD(MIN_HOLD)) u_pad2 (
        .clk      (clk),
        .reset    (reset),
        .ev_make  (hit2 && ps2_key[9]),
        .ev_break (hit2 && !ps2_key[9]),
        .digit    (dec2.idx),
        .down     (kp2_down)
    );

    // Toggle history, select latch and registered active-low flags
    always_ff @(posedge clk) begin
        if (reset) begin
            tog_prev <= ps2_key[10];
            key_sel  <= SEL_RESET;
            ef3_n    <= 1'b1;
            ef4_n    <= 1'b1;
        end else begin
            tog_prev <= ps2_key[10];
            if (io_out && io_n == KEY_PORT) key_sel <= io_dout[3:0];
            ef3_n <= ~(key_sel <= 4'd9 && kp1_down[key_sel]);
            ef4_n <= ~(key_sel <= 4'd9 && kp2_down[key_sel]);
        end
    end

endmodule

// File: tb/tb_studio2_keypad.sv
// Self-checking bench for studio2_keypad: time-based reference model plus literal checks.
module tb_studio2_keypad;

    localparam int H = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = '0;
    logic        io_out = 1'b0;
    logic [2:0]  io_n = '0;
    logic [7:0]  io_dout = '0;
    logic        ef3_n, ef4_n, z_ef3_n, z_ef4_n;
    logic [3:0]  key_sel, z_key_sel;
    logic [9:0]  kp1_down, kp2_down, z_kp1_down, z_kp2_down;

    studio2_keypad #(.MIN_HOLD(20'd16), .SEL_RESET(4'hF)) u_dut (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .io_out(io_out), .io_n(io_n),
        .io_dout(io_dout), .ef3_n(ef3_n), .ef4_n(ef4_n), .key_sel(key_sel),
        .kp1_down(kp1_down), .kp2_down(kp2_down)
    );

    studio2_keypad #(.MIN_HOLD(20'd0), .SEL_RESET(4'hF)) u_dut0 (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .io_out(io_out), .io_n(io_n),
        .io_dout(io_dout), .ef3_n(z_ef3_n), .ef4_n(z_ef4_n), .key_sel(z_key_sel),
        .kp1_down(z_kp1_down), .kp2_down(z_kp2_down)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] tbl [2][10] = '{
        '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46},
        '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D}
    };

    function automatic int find(input logic [7:0] code, input int pad);
        for (int i = 0; i < 10; i++) if (tbl[pad][i] == code) return i;
        return -1;
    endfunction

    logic [9:0] m_down [2];
    logic [9:0] m_pend [2];
    int         m_hold_end [2];   // last edge at which the hold still defers releases
    int         ecnt = 0;
    logic [3:0] m_sel;
    logic       m_ef3, m_ef4, m_prev;

    always @(posedge clk) begin
        int  k;
        bit  mk, br, n3, n4, ev;
        ecnt++;
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                m_down[p] = '0; m_pend[p] = '0; m_hold_end[p] = -1;
            end
            m_sel = 4'hF; m_ef3 = 1'b1; m_ef4 = 1'b1; m_prev = ps2_key[10];
        end else begin
            n3 = !(m_sel <= 9 && m_down[0][m_sel] === 1'b1);
            n4 = !(m_sel <= 9 && m_down[1][m_sel] === 1'b1);
            ev = (ps2_key[10] != m_prev);
            m_prev = ps2_key[10];
            for (int p = 0; p < 2; p++) begin
                k  = (ev && !ps2_key[8]) ? find(ps2_key[7:0], p) : -1;
                mk = (k >= 0) && ps2_key[9];
                br = (k >= 0) && !ps2_key[9];
                if (br) begin
                    if (ecnt <= m_hold_end[p]) m_pend[p][k] = 1'b1;
                    else                       m_down[p][k] = 1'b0;
                end
                if (ecnt == m_hold_end[p] && !mk) begin
                    m_down[p] = m_down[p] & ~m_pend[p];
                    m_pend[p] = '0;
                end
                if (mk) begin
                    m_down[p][k] = 1'b1;
                    m_pend[p][k] = 1'b0;
                    m_hold_end[p] = (H > 0) ? ecnt + H - 1 : -1;
                end
            end
            if (io_out && io_n == 3'd2) m_sel = io_dout[3:0];
            m_ef3 = n3;
            m_ef4 = n4;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ef3_n", 32'(ef3_n), 32'(m_ef3));
            chk("ef4_n", 32'(ef4_n), 32'(m_ef4));
            chk("key_sel", 32'(key_sel), 32'(m_sel));
            chk("kp1_down", 32'(kp1_down), 32'(m_down[0]));
            chk("kp2_down", 32'(kp2_down), 32'(m_down[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] code, input logic pressed, input logic ext);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        @(negedge clk);
    endtask

    task automatic out_sel(input logic [7:0] v);
        io_out = 1'b1; io_n = 3'd2; io_dout = v;
        @(negedge clk);
        io_out = 1'b0; io_n = 3'd0;
    endtask

    initial begin
        step(3);
        chk_en = 1'b1;
        chk("rst ef3_n", 32'(ef3_n), 32'd1);
        chk("rst ef4_n", 32'(ef4_n), 32'd1);
        chk("rst key_sel", 32'(key_sel), 32'hF);
        chk("rst kp1", 32'(kp1_down), 32'd0);
        chk("rst kp2", 32'(kp2_down), 32'd0);
        reset = 1'b0;
        step(2);

        // Make 1E (pad1 digit 2), then select 2
        press(8'h1E, 1'b1, 1'b0);
        chk("kp1 1E", 32'(kp1_down), 32'h004);
        out_sel(8'h02);
        chk("sel 2", 32'(key_sel), 32'd2);
        chk("ef3 lag", 32'(ef3_n), 32'd1);
        step(1);
        chk("ef3 sel2", 32'(ef3_n), 32'd0);
        chk("ef4 sel2", 32'(ef4_n), 32'd1);
        press(8'h1E, 1'b0, 1'b0);
        step(20);
        chk("kp1 cleared", 32'(kp1_down), 32'd0);

        // Short tap stretched to the minimum hold
        press(8'h1E, 1'b1, 1'b0);
        step(2);
        press(8'h1E, 1'b0, 1'b0);
        step(11);
        chk("hold kp1 +14", 32'(kp1_down), 32'h004);
        chk("hold ef3 +14", 32'(ef3_n), 32'd0);
        step(1);
        chk("hold kp1 +15", 32'(kp1_down), 32'd0);
        chk("hold ef3 +15", 32'(ef3_n), 32'd0);
        step(1);
        chk("hold ef3 +16", 32'(ef3_n), 32'd1);

        // Long press: release is immediate
        press(8'h1E, 1'b1, 1'b0);
        step(40);
        press(8'h1E, 1'b0, 1'b0);
        chk("long kp1", 32'(kp1_down), 32'd0);
        chk("long ef3 lag", 32'(ef3_n), 32'd0);
        step(1);
        chk("long ef3", 32'(ef3_n), 32'd1);

        // Keypad 2 digit 5, then select C
        out_sel(8'h05);
        press(8'h73, 1'b1, 1'b0);
        step(1);
        chk("kp2 d5", 32'(kp2_down), 32'h020);
        chk("ef4 d5", 32'(ef4_n), 32'd0);
        chk("ef3 d5", 32'(ef3_n), 32'd1);
        out_sel(8'h0C);
        chk("ef4 lag C", 32'(ef4_n), 32'd0);
        step(1);
        chk("ef4 sel C", 32'(ef4_n), 32'd1);
        chk("ef3 sel C", 32'(ef3_n), 32'd1);

        // Extended 75 and a non-digit code are ignored
        out_sel(8'hF8);
        press(8'h75, 1'b1, 1'b1);
        press(8'h1C, 1'b1, 1'b0);
        step(2);
        chk("ext sel", 32'(key_sel), 32'd8);
        chk("ext kp2", 32'(kp2_down), 32'h020);
        chk("ext kp1", 32'(kp1_down), 32'd0);
        chk("ext ef4", 32'(ef4_n), 32'd1);

        // Wrong N lines do not touch the latch
        io_out = 1'b1; io_n = 3'd3; io_dout = 8'h01;
        step(1);
        io_out = 1'b0; io_n = 3'd0;
        chk("io_n 3 ignored", 32'(key_sel), 32'd8);

        // Latch write and key event in the same cycle
        io_out = 1'b1; io_n = 3'd2; io_dout = 8'h00;
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h45};
        step(1);
        io_out = 1'b0; io_n = 3'd0;
        chk("sim sel", 32'(key_sel), 32'd0);
        chk("sim kp1", 32'(kp1_down), 32'h001);
        step(1);
        chk("sim ef3", 32'(ef3_n), 32'd0);
        press(8'h46, 1'b1, 1'b0);
        out_sel(8'h09);
        step(1);
        chk("multi kp1", 32'(kp1_down), 32'h201);
        chk("multi ef3", 32'(ef3_n), 32'd0);

        // Reset mid-hold discards pending state
        press(8'h16, 1'b1, 1'b0);
        step(3);
        reset = 1'b1;
        step(1);
        chk("mid rst kp1", 32'(kp1_down), 32'd0);
        chk("mid rst kp2", 32'(kp2_down), 32'd0);
        chk("mid rst sel", 32'(key_sel), 32'hF);
        chk("mid rst ef3", 32'(ef3_n), 32'd1);
        reset = 1'b0;
        step(2);
        press(8'h16, 1'b0, 1'b0);
        step(20);
        chk("post rst kp1", 32'(kp1_down), 32'd0);

        // MIN_HOLD=0 instance releases on the very next break
        press(8'h26, 1'b1, 1'b0);
        chk("h0 make", 32'(z_kp1_down), 32'h008);
        press(8'h26, 1'b0, 1'b0);
        chk("h0 break", 32'(z_kp1_down), 32'd0);
        chk("h16 held", 32'(kp1_down), 32'h008);
        step(20);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
